// File: rtl/load_controller_pkg.sv
// ---------------------------------------------------------------------------
// load_controller_pkg
// Shared definitions for the multicycle load sequencer:
//   - load type / datapath mask encodings (LD_W, LD_H, LD_B)
//   - sequencer state encoding
//   - wait counter width
//   - helpers to normalise the request type and check address alignment
// ---------------------------------------------------------------------------
package load_controller_pkg;

  // Load type encoding; identical to the datapath load-mask control code.
  localparam logic [1:0] LD_W = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_B = 2'b10;

  // Sequencer state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  // Wait counter width; covers memory latencies 1..15.
  localparam int CNT_W = 4;

  // The reserved encoding 11 behaves as a word load.
  function automatic logic [1:0] norm_type(input logic [1:0] ld_type);
    logic [1:0] res;
    case (ld_type)
      LD_H:    res = LD_H;
      LD_B:    res = LD_B;
      default: res = LD_W;
    endcase
    return res;
  endfunction

  // Natural alignment check on the two low address bits.
  function automatic logic is_aligned(input logic [1:0] ld_type, input logic [1:0] addr_lo);
    logic res;
    case (ld_type)
      LD_W:    res = (addr_lo == 2'b00);
      LD_H:    res = (addr_lo[0] == 1'b0);
      LD_B:    res = 1'b1;
      default: res = (addr_lo == 2'b00);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_controller_extract.sv
// ---------------------------------------------------------------------------
// load_extract
// Combinational extraction of the load value from the memory data word.
// Uses the same encoding as the datapath load mask so that ct and rf_wdata
// always describe the same result.
//   mdr      in  32  memory data word
//   ld_type  in   2  load type (LD_W / LD_H / LD_B, 11 treated as word)
//   data     out 32  zero-extended load value
// ---------------------------------------------------------------------------
module load_extract
  import load_controller_pkg::*;
(
  input  logic [31:0] mdr,
  input  logic [1:0]  ld_type,
  output logic [31:0] data
);

  // Select the upper halfword / byte and zero-extend it.
  always_comb begin
    data = mdr;
    case (ld_type)
      LD_W:    data = mdr;
      LD_H:    data = {16'h0000, mdr[31:16]};
      LD_B:    data = {24'h000000, mdr[31:24]};
      default: data = mdr;
    endcase
  end

endmodule

// File: rtl/load_controller.sv
// ---------------------------------------------------------------------------
// load_controller
// Multicycle load sequencer: accepts one load request, issues the memory
// read, waits MEM_LATENCY cycles, captures the returned word into the MDR
// and pulses a register-file write with the extracted value. Misaligned
// requests finish one cycle after the start with an error pulse.
//
// Parameters:
//   MEM_LATENCY  cycles from mem_rd to valid mem_data (1..15)
// Ports:
//   clk        in   1   system clock
//   reset      in   1   asynchronous active-low reset
//   start      in   1   request strobe, sampled only in IDLE
//   load_type  in   2   00 word, 01 halfword, 10 byte, 11 word
//   addr       in  32   byte address of the load
//   dest_reg   in   5   destination register index
//   busy       out  1   high in every state except IDLE
//   mem_addr   out 32   latched request address
//   mem_rd     out  1   memory read strobe (ISSUE cycle)
//   mem_data   in  32   memory read data
//   ct         out  2   load-mask control code (latched type while busy)
//   rf_we      out  1   register-file write enable pulse
//   rf_waddr   out  5   latched dest_reg
//   rf_wdata   out 32   extracted, zero-extended load value
//   done       out  1   completion pulse (success or error)
//   addr_err   out  1   misalignment pulse, coincident with done
// ---------------------------------------------------------------------------
module load_controller
  import load_controller_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  load_type,
  input  logic [31:0] addr,
  input  logic [4:0]  dest_reg,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  output logic [1:0]  ct,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        done,
  output logic        addr_err
);

  // Counter preload: the WAIT state lasts MEM_LATENCY cycles, the last
  // of which sees the counter at zero.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        type_r;
  logic [1:0]        type_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [31:0]       mdr_r;
  logic [31:0]       mdr_next_s;
  logic [31:0]       extract_s;
  logic              start_take_s;
  logic              capture_s;

  // Next-state, counter and latch-enable decode for the sequencer.
  always_comb begin
    state_next_s = state_r;
    type_next_s  = type_r;
    cnt_next_s   = cnt_r;
    start_take_s = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_take_s = 1'b1;
          type_next_s  = norm_type(load_type);
          if (is_aligned(norm_type(load_type), addr[1:0])) begin
            state_next_s = ST_ISSUE;
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_next_s   = WAIT_LOAD;
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          capture_s    = 1'b1;
          state_next_s = ST_WRITE;
        end else begin
          cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_next_s = ST_WAIT;
        end
      end
      ST_WRITE: state_next_s = ST_IDLE;
      ST_ERR:   state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Value the MDR will hold after this edge; the write data is extracted
  // from it so rf_wdata is registered in the same edge as the MDR capture.
  always_comb begin
    if (capture_s) begin
      mdr_next_s = mem_data;
    end else begin
      mdr_next_s = mdr_r;
    end
  end

  load_extract u_extract (
    .mdr     (mdr_next_s),
    .ld_type (type_r),
    .data    (extract_s)
  );

  // Sequencer state, latched request fields, MDR and registered outputs.
  // Outputs are decoded from the next state so they line up with the
  // state they describe while remaining flop outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      type_r   <= LD_W;
      cnt_r    <= {CNT_W{1'b0}};
      mdr_r    <= 32'h0000_0000;
      mem_addr <= 32'h0000_0000;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'h0000_0000;
      busy     <= 1'b0;
      mem_rd   <= 1'b0;
      rf_we    <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
      ct       <= LD_W;
    end else begin
      state_r <= state_next_s;
      type_r  <= type_next_s;
      cnt_r   <= cnt_next_s;
      mdr_r   <= mdr_next_s;
      if (start_take_s) begin
        mem_addr <= addr;
        rf_waddr <= dest_reg;
      end
      if (capture_s) begin
        rf_wdata <= extract_s;
      end
      busy     <= (state_next_s != ST_IDLE);
      mem_rd   <= (state_next_s == ST_ISSUE);
      rf_we    <= (state_next_s == ST_WRITE);
      done     <= (state_next_s == ST_WRITE) || (state_next_s == ST_ERR);
      addr_err <= (state_next_s == ST_ERR);
      ct       <= (state_next_s != ST_IDLE) ? type_next_s : LD_W;
    end
  end

endmodule

// File: tb/tb_load_controller.sv
// ---------------------------------------------------------------------------
// tb_load_controller
// Self-checking bench for load_controller. A default-latency instance runs
// a vector table through a scoreboard; a MEM_LATENCY=4 instance covers the
// capture timing, ignored starts and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_load_controller;

  typedef struct {
    logic [1:0]  lt;
    logic [31:0] addr;
    logic [4:0]  dest;
    logic [31:0] md;
    logic        err;
    logic [31:0] wdata;
    logic [1:0]  ct;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] wdata;
    logic [4:0]  dest;
    logic [1:0]  ct;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start0, start4;
  logic [1:0]  load_type;
  logic [31:0] addr;
  logic [4:0]  dest_reg;
  logic [31:0] mem_data;

  logic        busy0, mem_rd0, rf_we0, done0, addr_err0;
  logic [31:0] mem_addr0, rf_wdata0;
  logic [1:0]  ct0;
  logic [4:0]  rf_waddr0;

  logic        busy4, mem_rd4, rf_we4, done4, addr_err4;
  logic [31:0] mem_addr4, rf_wdata4;
  logic [1:0]  ct4;
  logic [4:0]  rf_waddr4;

  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  load_controller u0 (
    .clk(clk), .reset(rst_n), .start(start0), .load_type(load_type),
    .addr(addr), .dest_reg(dest_reg), .busy(busy0), .mem_addr(mem_addr0),
    .mem_rd(mem_rd0), .mem_data(mem_data), .ct(ct0), .rf_we(rf_we0),
    .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .done(done0), .addr_err(addr_err0)
  );

  load_controller #(.MEM_LATENCY(4)) u4 (
    .clk(clk), .reset(rst_n), .start(start4), .load_type(load_type),
    .addr(addr), .dest_reg(dest_reg), .busy(busy4), .mem_addr(mem_addr4),
    .mem_rd(mem_rd4), .mem_data(mem_data), .ct(ct4), .rf_we(rf_we4),
    .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .done(done4), .addr_err(addr_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every completion of the default instance.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected done", 32'(done0), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb addr_err", 32'(addr_err0), 32'(mon_e.err));
        check("sb rf_we", 32'(rf_we0), 32'(!mon_e.err));
        check("sb ct", 32'(ct0), 32'(mon_e.ct));
        check("sb rf_waddr", 32'(rf_waddr0), 32'(mon_e.dest));
        if (!mon_e.err) check("sb rf_wdata", rf_wdata0, mon_e.wdata);
      end
    end
  end

  // One request on the default-latency instance with timing checks.
  task automatic run0(input vec_t v);
    int n;
    int rd_cnt;
    int rd_cyc;
    exp_t e;
    @(negedge clk);
    load_type = v.lt; addr = v.addr; dest_reg = v.dest; mem_data = v.md;
    start0 = 1'b1;
    e.err = v.err; e.wdata = v.wdata; e.dest = v.dest; e.ct = v.ct;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    n = 1; rd_cnt = 0; rd_cyc = 0;
    while (1) begin
      if (mem_rd0) begin rd_cnt++; rd_cyc = n; end
      check("busy", 32'(busy0), 32'd1);
      if (done0) break;
      if (n >= 20) begin
        check("done timeout", 32'(done0), 32'd1);
        break;
      end
      n++;
      @(negedge clk);
    end
    check("latency", 32'(n), v.err ? 32'd1 : 32'd3);
    check("mem_rd count", 32'(rd_cnt), v.err ? 32'd0 : 32'd1);
    if (!v.err) check("mem_rd cycle", 32'(rd_cyc), 32'd1);
    check("mem_addr", mem_addr0, v.addr);
    @(negedge clk);
    check("idle after", 32'({busy0, done0, rf_we0, addr_err0, ct0}), 32'd0);
  endtask

  // One plain request on the latency-4 instance, constant memory data.
  task automatic run4(input logic [1:0] lt, input logic [31:0] a, input logic [4:0] d,
                      input logic [31:0] md, input logic [31:0] exp_w);
    int n;
    @(negedge clk);
    load_type = lt; addr = a; dest_reg = d; mem_data = md; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("lat4 latency", 32'(n), 32'd6);
    check("lat4 rf_we", 32'(rf_we4), 32'd1);
    check("lat4 rf_wdata", rf_wdata4, exp_w);
    check("lat4 rf_waddr", 32'(rf_waddr4), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int we_cnt;
    int rd_cnt;
    int rd_cyc;
    int done_cyc;

    vecs[0] = '{2'b00, 32'h0000_0100, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 2'b00};
    vecs[1] = '{2'b01, 32'h0000_0102, 5'd7,  32'hCAFE_1234, 1'b0, 32'h0000_CAFE, 2'b01};
    vecs[2] = '{2'b10, 32'h0000_0103, 5'd9,  32'hCAFE_1234, 1'b0, 32'h0000_00CA, 2'b10};
    vecs[3] = '{2'b00, 32'h0000_0102, 5'd3,  32'h1111_1111, 1'b1, 32'h0000_0000, 2'b00};
    vecs[4] = '{2'b01, 32'h0000_0101, 5'd4,  32'h2222_2222, 1'b1, 32'h0000_0000, 2'b01};
    vecs[5] = '{2'b11, 32'h0000_0204, 5'd31, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF, 2'b00};
    vecs[6] = '{2'b10, 32'h0000_0001, 5'd1,  32'h5A00_0000, 1'b0, 32'h0000_005A, 2'b10};
    vecs[7] = '{2'b01, 32'h0000_0002, 5'd2,  32'hFFFF_0000, 1'b0, 32'h0000_FFFF, 2'b01};
    vecs[8] = '{2'b11, 32'h0000_0003, 5'd6,  32'h3333_3333, 1'b1, 32'h0000_0000, 2'b00};

    tests = 0; fails = 0;
    rst_n = 1'b0; start0 = 1'b0; start4 = 1'b0;
    load_type = 2'b00; addr = 32'h0; dest_reg = 5'd0; mem_data = 32'h0;
    repeat (2) @(negedge clk);
    check("reset ctrl", 32'({busy0, mem_rd0, rf_we0, done0, addr_err0, ct0}), 32'd0);
    check("reset mem_addr", mem_addr0, 32'h0);
    check("reset rf_waddr", 32'(rf_waddr0), 32'd0);
    check("reset rf_wdata", rf_wdata0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run0(vecs[i]);
    end

    // Latency 4: decoy data in the cycle before capture; starts in WAIT and WRITE ignored.
    @(negedge clk);
    load_type = 2'b00; addr = 32'h0000_0040; dest_reg = 5'd10; mem_data = 32'hFFFF_FFFF;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    we_cnt = 0; rd_cnt = 0; rd_cyc = 0; done_cyc = 0;
    for (n = 1; n <= 8; n++) begin
      if (mem_rd4) begin rd_cnt++; rd_cyc = n; end
      if (rf_we4) we_cnt++;
      if (n == 4) check("lat4 mem_addr after start in WAIT", mem_addr4, 32'h0000_0040);
      if (done4) begin
        done_cyc = n;
        check("lat4 capture", rf_wdata4, 32'h600D_CAFE);
        check("lat4 ct", 32'(ct4), 32'd0);
        check("lat4 waddr", 32'(rf_waddr4), 32'd10);
      end
      if (n == 7) begin
        check("lat4 start in WRITE ignored", 32'(busy4), 32'd0);
        check("lat4 mem_addr held", mem_addr4, 32'h0000_0040);
      end
      mem_data = (n == 4) ? 32'h0BAD_0004 : ((n == 5) ? 32'h600D_CAFE : 32'hFFFF_FFFF);
      start4 = 1'b0;
      if (n == 3) begin start4 = 1'b1; addr = 32'h0000_0080; load_type = 2'b10; end
      if (n == 6) begin start4 = 1'b1; addr = 32'h0000_0084; end
      @(negedge clk);
    end
    start4 = 1'b0;
    check("lat4 done cycle", 32'(done_cyc), 32'd6);
    check("lat4 rf_we count", 32'(we_cnt), 32'd1);
    check("lat4 mem_rd count", 32'(rd_cnt), 32'd1);
    check("lat4 mem_rd cycle", 32'(rd_cyc), 32'd1);

    // Reset during WAIT aborts the read with no write.
    @(negedge clk);
    load_type = 2'b01; addr = 32'h0000_0010; dest_reg = 5'd3; mem_data = 32'h1234_5678;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    repeat (2) @(negedge clk);
    check("busy before reset", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort ctrl", 32'({busy4, mem_rd4, rf_we4, done4, addr_err4, ct4}), 32'd0);
    check("abort mem_addr", mem_addr4, 32'h0);
    check("abort rf_waddr", 32'(rf_waddr4), 32'd0);
    check("abort rf_wdata", rf_wdata4, 32'h0);
    we_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (rf_we4 || done4) we_cnt++;
    end
    check("abort no rf_we", 32'(we_cnt), 32'd0);

    run4(2'b01, 32'h0000_0010, 5'd3, 32'h1234_5678, 32'h0000_1234);
    run0(vecs[2]);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_controller.md
# load_controller

Multicycle load sequencer for the CPU datapath. It accepts one load request (word, halfword or byte) from the main control unit, issues the memory read, and waits a fixed memory latency. It captures the returned word into an internal MDR, drives the load-mask control code and the extracted value, then pulses a register-file write. It replaces the hand-sequenced load states in the main control FSM.

## Interface
- MEM_LATENCY, 1, cycles from `mem_rd` assertion to `mem_data` valid; legal range 1..15.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- start  in  1  request strobe; sampled only in IDLE.
- load_type  in  2  00 word, 01 halfword (MR[31:16]), 10 byte (MR[31:24]), 11 treated as word.
- addr  in  32  byte address of the load.
- dest_reg  in  5  destination register index.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  32  latched request address.
- mem_rd  out  1  memory read strobe.
- mem_data  in  32  memory read data.
- ct  out  2  load-mask control code for the datapath mask.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  5  latched `dest_reg`.
- rf_wdata  out  32  extracted, zero-extended load value.
- done  out  1  one-cycle completion pulse, on success or error.
- addr_err  out  1  one-cycle misalignment pulse, coincident with `done`.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, ERR.
- IDLE, `start`=1:
  - latch `addr`, `dest_reg` and `load_type`; 11 is latched as 00.
  - check alignment: word needs addr[1:0]=00; halfword needs addr[0]=0; byte is always aligned.
  - aligned -> ISSUE; misaligned -> ERR.
- ISSUE: `mem_rd`=1 for exactly this cycle; load the wait counter with MEM_LATENCY-1; -> WAIT.
- WAIT:
  - counter decrements each cycle.
  - when the counter is 0, `mem_data` is valid; capture it into MDR at that edge and go to WRITE.
- WRITE: `rf_we`=1, `done`=1, `rf_wdata`=extract(MDR, latched type); -> IDLE.
- ERR: `done`=1, `addr_err`=1; no `mem_rd`, no `rf_we`; -> IDLE.
- Extract rules:
  - 00: MDR.
  - 01: {16'b0, MDR[31:16]}.
  - 10: {24'b0, MDR[31:24]}.
- `ct` equals the latched type in all busy states; 00 in IDLE.
- `mem_addr` holds the latched address from ISSUE through WRITE; it holds its last value in IDLE.
- `start` while busy is ignored, with no queueing.
- `start` in the WRITE cycle is ignored; back-to-back requests need one IDLE cycle.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `mem_rd`, `rf_we`, `done`, `addr_err` = 0.
  - `ct`=00.
  - `mem_addr`, `rf_waddr`, `rf_wdata`, MDR = 0.
- Start sampled at edge T. ISSUE occupies cycle T+1, WAIT occupies T+2..T+1+MEM_LATENCY, and WRITE occurs at T+2+MEM_LATENCY.
- Latency from start to `done`: MEM_LATENCY+2 cycles (3 at default).
- Error latency: `done`/`addr_err` one cycle after the start edge.
- `rf_wdata` is registered: valid during WRITE and held until the next capture.
- Reset asserted mid-operation aborts immediately:
  - all outputs return to reset values.
  - any read in flight is discarded; no `rf_we` is issued for it.
- All outputs are registered or decoded from the state only, with no combinational path from inputs.

## Structure
- Shared package holds:
  - load type constants: LD_W=2'b00, LD_H=2'b01, LD_B=2'b10.
  - the state enum.
  - the 4-bit wait counter width.
- One sub-module: `load_extract`, combinational, taking (mdr, type) and producing zero-extended data. It uses the same encoding as the datapath mask so `ct` and `rf_wdata` always agree.

## Test plan
- Word load, default latency: addr=0x100, dest=5, mem_data=0xDEADBEEF -> `mem_rd` at T+1; `rf_we`, `done` at T+3; rf_wdata=0xDEADBEEF, rf_waddr=5, ct=00.
- Halfword and byte: mem_data=0xCAFE1234 -> type 01 gives 0x0000CAFE with ct=01; type 10 gives 0x000000CA with ct=10.
- Misaligned: type 00 at addr=0x102 -> ERR at T+1 with `addr_err`=1, `done`=1, no `mem_rd`, no `rf_we`. Type 01 at addr=0x101 behaves the same. Type 10 at addr=0x103 succeeds.
- MEM_LATENCY=4: `done` at T+6; MDR captures the value present at T+5; a different value at T+4 is ignored.
- `start` pulsed during WAIT and during WRITE with new addr -> ignored; mem_addr unchanged; exactly one `rf_we`. Type 11 -> ct=00 and a word result.
- Reset driven low during WAIT -> all outputs 0 within the same cycle; no `rf_we`. After release, a new request completes normally.
